// File: rtl/arm_pkg.sv
// Shared ARM datapath types and constants.
//   word_t        : 32-bit datapath word
//   fetch_state_t : fetch FSM states {IDLE, REQ, DROP}
//   PC_STEP       : sequential fetch increment
//   PC_AHEAD      : offset of the architectural PC seen by an instruction
package arm_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned PC_STEP  = 4;
   localparam int unsigned PC_AHEAD = 8;

   typedef logic [XLEN-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

endpackage : arm_pkg

// File: rtl/pc_target_mux.sv
// Redirect target selection for the fetch stage.
//   i_pc_wr     : R15 write this cycle (has priority)
//   i_pc_wdata  : value written to R15
//   i_br_pc8    : PC+8 of the branch
//   i_br_imm    : sign-extended, shifted branch offset
//   o_target_c  : combinational word-aligned redirect target
module pc_target_mux
   import arm_pkg::*;
(
   input  logic  i_pc_wr,
   input  word_t i_pc_wdata,
   input  word_t i_br_pc8,
   input  word_t i_br_imm,
   output word_t o_target_c
);

   word_t w_br_target;
   word_t w_sel;

   // Branch target wraps modulo 2^32; the carry is simply lost.
   assign w_br_target = i_br_pc8 + i_br_imm;
   assign w_sel       = i_pc_wr ? i_pc_wdata : w_br_target;
   assign o_target_c  = {w_sel[XLEN-1:2], 2'b00};

endmodule : pc_target_mux

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, imem req/ack fetch FSM and a
// one-entry valid/ready buffer towards decode.
//   clk, rst_n            : clock, async active-low reset
//   imem_req/addr/ack/rdata : instruction memory handshake
//   if_valid/ready/instr/pc8: decode-side buffer
//   br_taken/br_pc8/br_imm  : taken-branch redirect
//   pc_wr/pc_wdata          : R15 write redirect
module fetch_stage
   import arm_pkg::*;
#(
   parameter word_t RESET_PC = 32'h0000_0000
)
(
   input  logic  clk,
   input  logic  rst_n,
   output logic  imem_req,
   output word_t imem_addr,
   input  logic  imem_ack,
   input  word_t imem_rdata,
   output logic  if_valid,
   input  logic  if_ready,
   output word_t if_instr,
   output word_t if_pc8,
   input  logic  br_taken,
   input  word_t br_pc8,
   input  word_t br_imm,
   input  logic  pc_wr,
   input  word_t pc_wdata
);

   fetch_state_t r_state;
   word_t        r_pc;
   word_t        r_req_addr;
   logic         r_imem_req;
   logic         r_if_valid;
   word_t        r_if_instr;
   word_t        r_if_pc8;

   logic         w_redirect;
   logic         w_xfer;
   word_t        w_target;

   pc_target_mux u_pc_target_mux (
      .i_pc_wr    (pc_wr),
      .i_pc_wdata (pc_wdata),
      .i_br_pc8   (br_pc8),
      .i_br_imm   (br_imm),
      .o_target_c (w_target)
   );

   assign w_redirect = pc_wr | br_taken;
   assign w_xfer     = r_if_valid & if_ready;

   // Fetch FSM, PC and decode buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_pc       <= RESET_PC;
         r_req_addr <= RESET_PC;
         r_imem_req <= 1'b0;
         r_if_valid <= 1'b0;
         r_if_instr <= '0;
         r_if_pc8   <= '0;
      end else begin
         if (w_xfer) begin
            r_if_valid <= 1'b0;
         end

         if (w_redirect) begin
            // Flush wins over a same-cycle transfer or a returning ack.
            r_pc       <= w_target;
            r_if_valid <= 1'b0;
            case (r_state)
               IDLE: begin
                  r_state    <= IDLE;
                  r_imem_req <= 1'b0;
               end
               REQ, DROP: begin
                  // An outstanding request must still complete on the bus.
                  if (imem_ack) begin
                     r_state    <= IDLE;
                     r_imem_req <= 1'b0;
                  end else begin
                     r_state    <= DROP;
                     r_imem_req <= 1'b1;
                  end
               end
               default: begin
                  r_state    <= IDLE;
                  r_imem_req <= 1'b0;
               end
            endcase
         end else begin
            case (r_state)
               IDLE: begin
                  if (!r_if_valid || if_ready) begin
                     r_state    <= REQ;
                     r_req_addr <= r_pc;
                     r_imem_req <= 1'b1;
                     r_if_valid <= 1'b0;
                  end
               end
               REQ: begin
                  if (imem_ack) begin
                     r_if_instr <= imem_rdata;
                     r_if_pc8   <= r_req_addr + word_t'(PC_AHEAD);
                     r_if_valid <= 1'b1;
                     r_pc       <= r_pc + word_t'(PC_STEP);
                     r_state    <= IDLE;
                     r_imem_req <= 1'b0;
                  end
               end
               DROP: begin
                  if (imem_ack) begin
                     r_state    <= IDLE;
                     r_imem_req <= 1'b0;
                  end
               end
               default: begin
                  r_state    <= IDLE;
                  r_imem_req <= 1'b0;
               end
            endcase
         end
      end
   end

   assign imem_req  = r_imem_req;
   assign imem_addr = r_req_addr;
   assign if_valid  = r_if_valid;
   assign if_instr  = r_if_instr;
   assign if_pc8    = r_if_pc8;

endmodule : fetch_stage
